// File: rtl/wide_add_pkg.sv
// Shared constants and FSM encoding for the sequential wide adder.
package wide_add_pkg;

  localparam int unsigned SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : wide_add_pkg

// File: rtl/fulladder16bit.sv
// 16-bit ripple adder slice with carry in/out.
module fulladder16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        cin,
  output logic [15:0] S,
  output logic        cout
);

  assign {cout, S} = 17'(A) + 17'(B) + 17'(cin);

endmodule : fulladder16bit

// File: rtl/wide_add_seq.sv
// Multi-cycle W-bit adder: one 16-bit slice per cycle through a single shared adder.
// Optional macro WIDE_ADD_SUB_EN adds a 'sub' port for A-B (cout=1 means no borrow).
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int unsigned NSLICE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLICE_W*NSLICE-1:0] A,
  input  logic [SLICE_W*NSLICE-1:0] B,
  input  logic                      cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic                      sub,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SLICE_W*NSLICE-1:0] S,
  output logic                      cout
);

  localparam int unsigned IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t state_q, state_d;

  logic [NSLICE-1:0][SLICE_W-1:0] a_q, b_q, s_q;
  logic [IDX_W-1:0]               idx_q;
  logic                           carry_q;
  logic                           cout_q;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_co;
  logic [SLICE_W*NSLICE-1:0] b_in;
  logic                      c_in;

  // Subtract mode folds into addition: A + ~B + 1.
`ifdef WIDE_ADD_SUB_EN
  assign b_in = sub ? ~B : B;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = B;
  assign c_in = cin;
`endif

  fulladder16bit u_slice_add (
    .A    (a_q[idx_q]),
    .B    (b_q[idx_q]),
    .cin  (carry_q),
    .S    (slice_sum),
    .cout (slice_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture and per-slice accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= b_in;
            carry_q <= c_in;
            idx_q   <= '0;
          end
        end
        RUN: begin
          s_q[idx_q] <= slice_sum;
          carry_q    <= slice_co;
          idx_q      <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) cout_q <= slice_co;
        end
        default: ;
      endcase
    end
  end

  assign S    = s_q;
  assign cout = cout_q;

endmodule : wide_add_seq

// File: tb/tb_wide_add_seq.sv
// Directed self-checking bench for wide_add_seq (default NSLICE=4, W=64).
module tb_wide_add_seq;

  localparam int unsigned W = 64;
  localparam int TIMEOUT = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
`ifdef WIDE_ADD_SUB_EN
  logic         sub;
`endif

  int n_vec = 0;
  int n_err = 0;
  int lat;

  always #5 clk = ~clk;

  wide_add_seq #(.NSLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .cin       (cin),
`ifdef WIDE_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (s),
    .cout      (cout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for out_valid, returning edges elapsed; TIMEOUT marks a hang.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < TIMEOUT) begin
      step();
      cnt++;
    end
  endtask

  // Offer operands for one edge, then drop in_valid.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] exp_s, input logic exp_c);
    wait_done(lat);
    chk({tag, "_lat"}, W'(lat), W'(4));
    chk({tag, "_s"}, s, exp_s);
    chk({tag, "_cout"}, W'(cout), W'(exp_c));
    out_ready = 1'b1;
    chk({tag, "_hs_in_ready"}, W'(in_ready), W'(0));
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, W'(out_valid), W'(0));
    chk({tag, "_idle_ready"}, W'(in_ready), W'(1));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef WIDE_ADD_SUB_EN
    sub = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_s", s, '0);
    chk("rst_cout", W'(cout), W'(0));

    // Basic addition
    launch(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 1'b0);
    chk("basic_busy", W'(in_ready), W'(0));
    finish_op("basic", 64'h0000_0000_0000_0008, 1'b0);

    // Full ripple through every slice with wrap
    launch(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    finish_op("wrap_cin", 64'h0, 1'b1);
    launch(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    finish_op("ones_ones", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    launch(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    finish_op("slice0_carry", 64'h0000_0000_0001_0000, 1'b0);

    // Mixed pattern, then hold in DONE under backpressure
    launch(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    wait_done(lat);
    chk("bp_lat", W'(lat), W'(4));
    for (int i = 0; i < 3; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      cin = ~cin; in_valid = ~in_valid;
      step();
      chk("bp_s", s, 64'h2222_2222_2222_2211);
      chk("bp_cout", W'(cout), W'(0));
      chk("bp_valid", W'(out_valid), W'(1));
      chk("bp_in_ready", W'(in_ready), W'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_ready", W'(in_ready), W'(1));
    chk("bp_release_valid", W'(out_valid), W'(0));

    // Reset after two RUN cycles
    launch(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", W'(out_valid), W'(0));
    chk("mid_rst_s", s, '0);
    chk("mid_rst_cout", W'(cout), W'(0));
    chk("mid_rst_ready", W'(in_ready), W'(1));
    launch(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0200, 1'b0);
    finish_op("post_rst", 64'h0000_0000_0000_0300, 1'b0);

    // Back-to-back with in_valid held high; set 2 is on the bus during set 1
    a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555; cin = 1'b1;
    in_valid = 1'b1;
    step();
    a = 64'h0001_0002_0003_0004; b = 64'h0010_0020_0030_0040; cin = 1'b1;
    wait_done(lat);
    chk("b2b1_lat", W'(lat), W'(4));
    chk("b2b1_s", s, 64'h0);
    chk("b2b1_cout", W'(cout), W'(1));
    out_ready = 1'b1;
    chk("b2b_hs_in_ready", W'(in_ready), W'(0));
    step();
    out_ready = 1'b0;
    chk("b2b_gap_ready", W'(in_ready), W'(1));
    step();
    in_valid = 1'b0;
    chk("b2b2_accepted", W'(in_ready), W'(0));
    finish_op("b2b2", 64'h0011_0022_0033_0045, 1'b0);

`ifdef WIDE_ADD_SUB_EN
    sub = 1'b1;
    launch(64'h5, 64'h3, 1'b0);
    finish_op("sub_pos", 64'h2, 1'b1);
    launch(64'h3, 64'h5, 1'b0);
    finish_op("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    sub = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_wide_add_seq

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter NSLICE, default 4, number of 16-bit slices; operand width W = 16*NSLICE.
REQ-002 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  in  1  operands offered.
REQ-005 SHALL have port in_ready  out  1  block can accept operands.
REQ-006 SHALL have port A  in  W  first operand.
REQ-007 SHALL have port B  in  W  second operand.
REQ-008 SHALL have port cin  in  1  carry into slice 0.
REQ-009 SHALL have port out_valid  out  1  result available.
REQ-010 SHALL have port out_ready  in  1  consumer takes result.
REQ-011 SHALL have port S  out  W  sum.
REQ-012 SHALL have port cout  out  1  carry out of top slice.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 IDLE: on clk edge with in_valid=1, SHALL latch A, B, cin into operand/carry registers, clear slice index to 0, go RUN; in_valid=0 stays IDLE.
REQ-015 RUN: each cycle SHALL add slice idx (bits 16*idx+15..16*idx) of latched A, B plus carry register, write the 16-bit result to the same S slice and its carry-out to the carry register, then increment idx.
REQ-016 RUN SHALL go DONE on the edge processing idx=NSLICE-1; cout then equals that slice's carry-out.
REQ-017 Latency SHALL be exactly NSLICE cycles: out_valid rises NSLICE edges after the accepting edge (4 for default).
REQ-018 DONE: S and cout SHALL hold stable while out_ready=0; on the edge with out_ready=1 SHALL go IDLE.
REQ-019 In the cycle out_valid and out_ready are both 1, in_ready SHALL be 0; new operands are accepted no earlier than the following cycle (one IDLE cycle between results).
REQ-020 Input changes on A, B, cin during RUN/DONE SHALL NOT affect the result.
REQ-021 Carry SHALL ripple across slices: all-ones plus carry-in wraps S to 0 with cout=1; arithmetic is unsigned modulo 2^W.
REQ-022 S is checked only while out_valid=1; lower slices update progressively during RUN.

Reset
REQ-023 rst=1 at any edge, including mid-RUN or in DONE, SHALL force IDLE, idx=0, carry register=0, S=0, cout=0, out_valid=0, in_ready=1 the following cycle; any in-flight operation is discarded.
REQ-024 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-025 With macro WIDE_ADD_SUB_EN defined, SHALL add port sub  in  1, latched with operands; sub=1 uses ~B and forces initial carry to 1 regardless of cin, giving A-B with cout=1 meaning no borrow.
REQ-026 Without WIDE_ADD_SUB_EN, port sub SHALL be absent and behaviour SHALL be pure addition per REQ-015.

Structure
REQ-027 Shared package wide_add_pkg SHALL hold SLICE_W=16 and the FSM state encodings (IDLE, RUN, DONE).
REQ-028 Slice addition SHALL use one instance of the team's existing 16-bit adder fulladder16bit (ports A, B, cin, S, cout) as the only sub-module, time-shared across slices.

Verification
REQ-029 Basic: A=0x0000_0000_0000_0005, B=...0003, cin=0 -> out_valid after 4 cycles, S=...0008, cout=0.
REQ-030 Ripple/wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> S=0, cout=1; A=B=0xFFFF..FFFF, cin=0 -> S=0xFFFF..FFFE, cout=1.
REQ-031 Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling A/B/in_valid -> S, cout, out_valid unchanged, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-032 Reset mid-RUN: assert rst after 2 RUN cycles -> next cycle out_valid=0, S=0, cout=0, in_ready=1; a fresh add then completes with correct result in 4 cycles.
REQ-033 Back-to-back: in_valid held high with two operand sets -> second accepted exactly one cycle after first result's handshake; both results correct.
REQ-034 With WIDE_ADD_SUB_EN: A=5, B=3, sub=1 -> S=2, cout=1; A=3, B=5, sub=1 -> S=0xFFFF..FFFE, cout=0.
